// File: rtl/enable_gen_pkg.sv
// Shared definitions for the periodic enable generator.
//   EG_MODE_CLOCK / EG_MODE_PULSE : values accepted by the CLOCK_MODE parameter
//   EG_COUNTER_WIDTH              : default width of the period and cycle counter
package enable_gen_pkg;

  localparam string EG_MODE_CLOCK = "TRUE";
  localparam string EG_MODE_PULSE = "FALSE";

  localparam int EG_COUNTER_WIDTH = 32;

endpackage

// File: rtl/enable_gen_counter.sv
// Wrap counter with a shadowed period register.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high; clears cnt and period_r
//   run      : count while high; while low the counter idles at 0 and the
//              shadow follows the period input
//   period   : requested period in cycles (unsigned)
//   cnt      : current cycle count, 0 .. period_r-1
//   period_r : period currently in force (reloaded only at wrap or while idle)
//   wrap     : high during the last cycle of a period (cnt == period_r-1)
module enable_gen_counter
  import enable_gen_pkg::*;
#(
  parameter int COUNTER_WIDTH = EG_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] cnt,
  output logic [COUNTER_WIDTH-1:0] period_r,
  output logic                     wrap
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic period_zero;

  assign period_zero = (period_r == '0);

  // period_r - 1 underflows when period_r is 0, so the compare is gated.
  assign wrap = run && !period_zero && (cnt == period_r - ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      period_r <= '0;
    end else if (!run) begin
      cnt      <= '0;
      period_r <= period;
    end else if (period_zero) begin
      // Zero period disables counting; keep reloading the shadow so a
      // later non-zero period is not locked out until the next idle.
      cnt      <= '0;
      period_r <= period;
    end else if (wrap) begin
      cnt      <= '0;
      period_r <= period;
    end else begin
      cnt      <= cnt + ONE;
    end
  end

endmodule

// File: rtl/enable_gen_core.sv
// Programmable periodic enable generator.
// Produces a one-cycle strobe every `period` cycles (pulse mode) or a square
// wave high for floor(P/2) and low for ceil(P/2) cycles (clock mode), only
// while gen_enable_in is high.
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-high; clears all state
//   gen_enable_in : run enable
//   period        : output period in clock cycles (unsigned)
//   enable_out    : registered strobe / square wave
module enable_gen_core
  import enable_gen_pkg::*;
#(
  parameter string CLOCK_MODE    = EG_MODE_CLOCK,
  parameter int    COUNTER_WIDTH = EG_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     gen_enable_in,
  input  logic [COUNTER_WIDTH-1:0] period,
  output logic                     enable_out
);

  // Anything other than the clock-mode string falls back to pulse mode.
  localparam bit IS_CLOCK = (CLOCK_MODE == EG_MODE_CLOCK);

  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] period_r;
  logic                     wrap;
  logic [COUNTER_WIDTH-1:0] half;
  logic                     next_out;

  enable_gen_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .run      (gen_enable_in),
    .period   (period),
    .cnt      (cnt),
    .period_r (period_r),
    .wrap     (wrap)
  );

  assign half = period_r >> 1;

  // With period_r == 0, half is 0 and wrap is gated off, so both modes
  // naturally hold the output low.
  always_comb begin
    next_out = 1'b0;
    if (gen_enable_in) begin
      if (IS_CLOCK) next_out = (cnt < half);
      else          next_out = wrap;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) enable_out <= 1'b0;
    else       enable_out <= next_out;
  end

endmodule

// File: tb/tb_enable_gen_core.sv
// Directed testbench for enable_gen_core: one clock-mode and one pulse-mode
// instance share clock and reset; each has its own enable and period.
module tb_enable_gen_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        en_c, en_p;
  logic [31:0] per_c, per_p;
  logic        out_c, out_p;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  enable_gen_core #(.CLOCK_MODE("TRUE"), .COUNTER_WIDTH(32)) dut_clk (
    .clock        (clock),
    .reset        (reset),
    .gen_enable_in(en_c),
    .period       (per_c),
    .enable_out   (out_c)
  );

  enable_gen_core #(.CLOCK_MODE("FALSE"), .COUNTER_WIDTH(32)) dut_pls (
    .clock        (clock),
    .reset        (reset),
    .gen_enable_in(en_p),
    .period       (per_p),
    .enable_out   (out_p)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en_c  = 1'b0;
    en_p  = 1'b0;
    per_c = 32'd33;
    per_p = 32'd33;

    // Reset held for 3 cycles
    repeat (3) step();
    check_val("rst_clk", 32'(out_c), 32'd0);
    check_val("rst_pls", 32'(out_p), 32'd0);
    reset = 1'b0;
    step();
    check_val("idle_clk", 32'(out_c), 32'd0);
    check_val("idle_pls", 32'(out_p), 32'd0);

    // Clock mode 16 high / 17 low, pulse mode one strobe every 33 edges
    en_c = 1'b1;
    en_p = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      step();
      check_val($sformatf("clk_p33[%0d]", i), 32'(out_c), 32'(((i - 1) % 33) < 16));
      check_val($sformatf("pls_p33[%0d]", i), 32'(out_p), 32'((i % 33) == 0));
    end

    // Pulse mode: period change from 33 to 10 at cnt == 5
    en_p = 1'b0;
    step();
    check_val("pls_drop", 32'(out_p), 32'd0);
    en_p = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 5) per_p = 32'd10;
      check_val($sformatf("pls_chg[%0d]", i), 32'(out_p),
                32'((i == 33) || (i == 43) || (i == 53)));
    end

    // Clock mode: drop enable at cnt == 20, then restart
    en_c = 1'b0;
    step();
    en_c = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_val($sformatf("clk_pre[%0d]", i), 32'(out_c), 32'((i - 1) < 16));
    end
    en_c = 1'b0;
    step();
    check_val("clk_drop", 32'(out_c), 32'd0);
    en_c = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      check_val($sformatf("clk_re[%0d]", i), 32'(out_c), 32'((i - 1) < 16));
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      check_val($sformatf("clk_hi[%0d]", i), 32'(out_c), 32'd1);
    end

    // Asynchronous reset in the high phase, away from any clock edge
    #2 reset = 1'b1;
    #1;
    check_val("rst_async_clk", 32'(out_c), 32'd0);
    step();
    check_val("rst_hold_clk", 32'(out_c), 32'd0);
    check_val("rst_hold_pls", 32'(out_p), 32'd0);
    en_c  = 1'b0;
    en_p  = 1'b0;
    reset = 1'b0;

    // Degenerate periods 0, 1, 2 in both modes
    for (int p = 0; p <= 2; p++) begin
      per_c = 32'(p);
      per_p = 32'(p);
      en_c  = 1'b0;
      en_p  = 1'b0;
      step();
      en_c = 1'b1;
      en_p = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        step();
        check_val($sformatf("clk_deg%0d[%0d]", p, i), 32'(out_c),
                  (p == 2) ? 32'(((i - 1) % 2) == 0) : 32'd0);
        check_val($sformatf("pls_deg%0d[%0d]", p, i), 32'(out_p),
                  (p == 0) ? 32'd0 : (p == 1) ? 32'd1 : 32'((i % 2) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
